daq_arbiter: RTL and testbench

- Shares the single DAQ stream between up to NREQ sensor front-ends, e.g. as5311 channels and endstop and stepper samplers.
- Each front-end raises a request and waits for a one-cycle grant. It then emits a burst of 32-bit words with valid, closing on a word with end set.
- The arbiter grants round-robin and buffers bursts in a FIFO, because front-ends cannot take backpressure.
- It drives a ready/valid stream toward the DAQ packetiser.

---
 rtl/daq_arbiter_pkg.sv | 29 ++
 rtl/daq_fifo.sv | 68 ++++++
 rtl/daq_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_daq_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/daq_arbiter_pkg.sv
// Shared types for the DAQ arbiter: FIFO entry layout, FSM states, error causes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package daq_arbiter_pkg;

    localparam int DATA_W = 32;

    // One FIFO slot: end-of-burst flag above the data word.
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Why err pulsed; kept for debug visibility only.
    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_OVERLONG = 2'd2,
        ERR_STRAY    = 2'd3
    } err_cause_t;

endpackage

// File: rtl/daq_fifo.sv
// Synchronous FIFO with simultaneous push/pop and an occupancy count.
// Latency: a pushed word is visible on pop_dat the cycle after the push when empty.
// Backpressure: push is ignored when full unless a pop frees a slot the same cycle.
// Ports: clk/rst (sync, active-high); push/push_dat write side; pop/pop_dat read side;
//        full, empty and level (0..DEPTH) status.
module daq_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign level   = level_q;
    assign pop_dat = mem_q[rd_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: contents are only observed through level/empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_dat;
    end

endmodule

// File: rtl/daq_arbiter.sv
// Round-robin arbiter sharing one DAQ stream among NREQ burst front-ends, bursts buffered in a FIFO.
// Latency: grant 1 cycle after req sampled; word on out_data 1 cycle after its push into an empty FIFO.
// Backpressure: out_ready stalls the FIFO head; grants are withheld until MAX_BURST+1 entries are free.
// Ports: clk, rst (sync, active-high); req/grant handshake; in_data/in_valid/in_end per-requester
//        bursts; out_data/out_end/out_valid/out_ready stream; busy (burst owner active); err pulse.
// Optional: define DAQ_ARBITER_STATS_EN to add grant_cnt, err_cnt and max_level counters.
module daq_arbiter
    import daq_arbiter_pkg::*;
#(
    parameter int          NREQ       = 4,
    parameter int          DEPTH      = 16,
    parameter int          MAX_BURST  = 4,
    parameter int          TIMEOUT    = 64,
    parameter logic [31:0] ABORT_WORD = 32'hFFFF_FFFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          grant,
    input  logic [32*NREQ-1:0]       in_data,
    input  logic [NREQ-1:0]          in_valid,
    input  logic [NREQ-1:0]          in_end,
    output logic [31:0]              out_data,
    output logic                     out_end,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
`ifdef DAQ_ARBITER_STATS_EN
    output logic [16*NREQ-1:0]       grant_cnt,
    output logic [15:0]              err_cnt,
    output logic [$clog2(DEPTH):0]   max_level,
`endif
    output logic                     err
);

    localparam int OW = $clog2(NREQ);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            err_q, err_d;
    err_cause_t      cause;

    logic            push;
    entry_t          push_dat;
    entry_t          head;
    logic            fifo_full, fifo_empty;
    logic [LW-1:0]   level, free;

    logic            found;
    logic [OW-1:0]   winner;
    logic [OW:0]     idx;

    logic            in_burst;
    logic [NREQ-1:0] accept_mask;
    logic            stray;
    logic            own_vld, own_end;
    logic [31:0]     own_dat;

    daq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (out_valid && out_ready),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head.data;
    assign out_end   = head.last;
    assign grant     = grant_q;
    assign err       = err_q;
    assign busy      = (state_q == ST_BURST);
    assign free      = LW'(DEPTH) - level;

    // The owner's data is only accepted after its grant pulse has gone; a
    // word sent during the grant cycle itself counts as a stray.
    assign in_burst    = (state_q == ST_BURST) && (grant_q == '0);
    assign accept_mask = in_burst ? (NREQ'(1) << owner_q) : '0;
    assign stray       = |(in_valid & ~accept_mask);
    assign own_vld     = in_valid[owner_q];
    assign own_end     = in_end[owner_q];
    assign own_dat     = in_data[{owner_q, 5'b0} +: 32];

    // First requester at or after rr_q, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = rr_q;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_q} + (OW+1)'(k);
            if (idx >= (OW+1)'(NREQ)) idx = idx - (OW+1)'(NREQ);
            if (!found && req[idx[OW-1:0]]) begin
                found  = 1'b1;
                winner = idx[OW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        grant_d  = '0;
        cause    = ERR_NONE;
        push     = 1'b0;
        push_dat = '{last: 1'b1, data: ABORT_WORD};

        if (stray) cause = ERR_STRAY;

        case (state_q)
            ST_IDLE: begin
                // MAX_BURST+1 free slots cover a full burst plus its abort filler.
                if (found && !fifo_full && free >= LW'(MAX_BURST + 1)) begin
                    grant_d = NREQ'(1) << winner;
                    owner_d = winner;
                    rr_d    = (winner == OW'(NREQ - 1)) ? '0 : winner + 1'b1;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
                if (in_burst && own_vld) begin
                    if (cnt_q < CW'(MAX_BURST)) begin
                        push     = 1'b1;
                        push_dat = '{last: own_end, data: own_dat};
                        cnt_d    = cnt_q + 1'b1;
                        if (own_end) state_d = ST_IDLE;
                    end else begin
                        // Overlong: the word is dropped and the filler closes the burst.
                        cause   = ERR_OVERLONG;
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (tmo_q >= TW'(TIMEOUT - 1)) begin
                    // A word landing on the deadline is still taken; the abort then follows next cycle.
                    cause   = ERR_TIMEOUT;
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        endcase

        err_d = (cause != ERR_NONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            grant_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            grant_q <= grant_d;
            err_q   <= err_d;
        end
    end

`ifdef DAQ_ARBITER_STATS_EN
    logic [15:0]   grant_cnt_q [NREQ];
    logic [15:0]   grant_cnt_d [NREQ];
    logic [15:0]   err_cnt_q, err_cnt_d;
    logic [LW-1:0] max_level_q, max_level_d;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
            if (grant_d[i] && grant_cnt_q[i] != 16'hFFFF) grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
        end
        err_cnt_d = err_cnt_q;
        if (err_d && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        max_level_d = (level > max_level_q) ? level : max_level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) grant_cnt_q[i] <= '0;
            err_cnt_q   <= '0;
            max_level_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) grant_cnt_q[i] <= grant_cnt_d[i];
            err_cnt_q   <= err_cnt_d;
            max_level_q <= max_level_d;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_grant_cnt
        assign grant_cnt[16*g +: 16] = grant_cnt_q[g];
    end
    assign err_cnt   = err_cnt_q;
    assign max_level = max_level_q;
`endif

endmodule

// File: tb/tb_daq_arbiter.sv
// Directed bench for daq_arbiter: round-robin, backpressure, timeout, overlong, stray, reset.
// Latency: n/a.
// Backpressure: out_ready driven by the bench per phase.
module tb_daq_arbiter;

    localparam int          NREQ      = 4;
    localparam int          MAX_BURST = 4;
    localparam logic [31:0] ABORT     = 32'hFFFF_FFFF;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      grant;
    logic [32*NREQ-1:0]   in_data;
    logic [NREQ-1:0]      in_valid;
    logic [NREQ-1:0]      in_end;
    logic [31:0]          out_data;
    logic                 out_end;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 err;
`ifdef DAQ_ARBITER_STATS_EN
    logic [16*NREQ-1:0]   grant_cnt;
    logic [15:0]          err_cnt;
    logic [4:0]           max_level;
`endif

    always #5 clk = ~clk;

    daq_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .grant     (grant),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_end    (in_end),
        .out_data  (out_data),
        .out_end   (out_end),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
`ifdef DAQ_ARBITER_STATS_EN
        .grant_cnt (grant_cnt),
        .err_cnt   (err_cnt),
        .max_level (max_level),
`endif
        .err       (err)
    );

    int              checks = 0;
    int              errors = 0;
    int              err_pulses = 0;
    int              pops = 0;
    int              cyc = 0;
    logic [32:0]     exp_q [$];
    logic [NREQ-1:0] prev_grant = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output scoreboard, grant shape and err pulse counting, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                pops++;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_extra observed=%0h expected=no word", {out_end, out_data});
                end
                if (exp_q.size() != 0) check("sb_word", {out_end, out_data}, exp_q.pop_front());
            end
            if (grant != '0) begin
                check("grant_onehot", $onehot(grant), 1);
                check("grant_single_cycle", prev_grant, 0);
            end
            if (err) err_pulses++;
        end
        prev_grant = grant;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_any_grant(input int budget, output int idx, output bit ok);
        ok  = 1'b0;
        idx = -1;
        for (int c = 0; c < budget; c++) begin
            if (grant != '0) begin
                ok = 1'b1;
                for (int i = 0; i < NREQ; i++) if (grant[i]) idx = i;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_err(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (err) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Called in the grant cycle; words start the cycle after. Words beyond
    // MAX_BURST are not expected in the FIFO.
    task automatic send_burst(input int idx, input int n, input bit with_end, input logic [31:0] base);
        for (int w = 0; w < n; w++) begin
            tick();
            in_valid                 = '0;
            in_end                   = '0;
            in_valid[idx]            = 1'b1;
            in_data[32*idx +: 32]    = base + 32'(w);
            in_end[idx]              = with_end && (w == n - 1);
            if (w < MAX_BURST) exp_q.push_back({with_end && (w == n - 1), base + 32'(w)});
        end
        tick();
        in_valid = '0;
        in_end   = '0;
    endtask

    initial begin
        bit ok;
        int idx, c0, e0, p0;

        rst = 1'b1; req = '0; in_valid = '0; in_end = '0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_out_valid", out_valid, 0);
        rst = 1'b0;

        // Round-robin across all four requesters, wrapping back to 0.
        out_ready = 1'b1;
        req       = 4'b1111;
        e0        = err_pulses;
        for (int b = 0; b < 5; b++) begin
            wait_any_grant(300, idx, ok);
            check("rr_grant_seen", ok, 1);
            check("rr_grant_idx", idx, b % 4);
            if (b == 4) req = '0;
            if (ok) send_burst(idx, 2, 1'b1, 32'h1000_0000 + 32'(b * 16));
        end
        wait_drain(ok);
        check("rr_drain", ok, 1);
        check("rr_no_err", err_pulses - e0, 0);

        // Backpressure: three 4-word bursts fill 12 of 16; the fourth waits for a pop.
        out_ready = 1'b0;
        req       = 4'b0010;
        for (int b = 0; b < 3; b++) begin
            wait_any_grant(300, idx, ok);
            check("bp_grant_seen", ok, 1);
            check("bp_grant_idx", idx, 1);
            if (ok) send_burst(1, 4, 1'b1, 32'h2000_0000 + 32'(b * 16));
        end
        wait_any_grant(40, idx, ok);
        check("bp_withheld", ok, 0);
        check("bp_head_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_any_grant(10, idx, ok);
        check("bp_grant_after_pop", ok, 1);
        check("bp_grant_after_pop_idx", idx, 1);
        req = '0;
        if (ok) send_burst(1, 4, 1'b1, 32'h2000_0030);
        out_ready = 1'b1;
        wait_drain(ok);
        check("bp_drain", ok, 1);

        // Timeout: requester 2 sends one unterminated word.
        req = 4'b1100;
        e0  = err_pulses;
        wait_any_grant(300, idx, ok);
        c0 = cyc;
        check("tmo_grant_idx", idx, 2);
        if (ok) begin
            send_burst(2, 1, 1'b0, 32'hA5A5_0001);
            exp_q.push_back({1'b1, ABORT});
        end
        wait_err(100, ok);
        check("tmo_err_seen", ok, 1);
        check("tmo_err_cycle", cyc - c0, 64);
        wait_any_grant(20, idx, ok);
        check("tmo_next_grant_seen", ok, 1);
        check("tmo_next_grant_idx", idx, 3);
        req = '0;
        if (ok) send_burst(3, 1, 1'b1, 32'h3000_0003);
        wait_drain(ok);
        check("tmo_drain", ok, 1);
        tick();
        check("tmo_err_count", err_pulses - e0, 1);

        // Overlong: requester 0 sends five words without end.
        out_ready = 1'b0;
        req       = 4'b0001;
        e0        = err_pulses;
        wait_any_grant(300, idx, ok);
        check("ovl_grant_idx", idx, 0);
        req = '0;
        if (ok) begin
            send_burst(0, 5, 1'b0, 32'h4000_0000);
            exp_q.push_back({1'b1, ABORT});
        end
        tick();
        check("ovl_err_count", err_pulses - e0, 1);
        p0        = pops;
        out_ready = 1'b1;
        wait_drain(ok);
        check("ovl_drain", ok, 1);
        check("ovl_entries", pops - p0, 5);

        // Stray valid from a non-owner while idle.
        out_ready = 1'b0;
        e0        = err_pulses;
        tick();
        in_valid[3]     = 1'b1;
        in_data[127:96] = 32'hDEAD_0003;
        tick();
        in_valid = '0;
        tick();
        tick();
        check("stray_err_count", err_pulses - e0, 1);
        check("stray_no_push", out_valid, 0);

        // Reset in the middle of a burst drops the partial burst and the rr pointer.
        req = 4'b0010;
        wait_any_grant(300, idx, ok);
        check("rst_mid_grant_idx", idx, 1);
        check("rst_mid_busy", busy, 1);
        req = '0;
        tick();
        in_valid[1]     = 1'b1;
        in_data[63:32]  = 32'h5000_0001;
        tick();
        in_data[63:32]  = 32'h5000_0002;
        tick();
        in_valid = '0;
        check("rst_mid_pre_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        tick();
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_busy_clear", busy, 0);
        rst = 1'b0;
        req = 4'b1001;
        wait_any_grant(300, idx, ok);
        check("rst_mid_next_grant_idx", idx, 0);
        req = '0;
        if (ok) send_burst(0, 1, 1'b1, 32'h6000_0000);
        out_ready = 1'b1;
        wait_drain(ok);
        check("rst_mid_drain", ok, 1);
        check("total_err_pulses", err_pulses, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
